featuremap_accum_bias: RTL and testbench
========================================

# featuremap_accum_bias

Parametrised channel-reduction stage for the feature-map datapath: sums NUM_CHANNELS per-channel conv2D results for one output pixel through a registered adder tree, adds the per-filter bias, saturates, and optionally applies ReLU. Output uses a valid/ready handshake with full back-pressure. Row and frame counters tag each output pixel with end-of-row and end-of-frame flags. It replaces fixed 16-channel bias adders: channel count, data width, bias, activation and frame geometry are all parameters.

## Interface
- DATA_WIDTH, 16: signed two's-complement fixed-point width of each channel input and of the output.
- NUM_CHANNELS, 16: number of input channels, ≥2. Non-power-of-two counts are zero-padded to the next power of two.
- BIAS, 0: signed DATA_WIDTH bias, in the same Q format as the inputs.
- RELU_EN, 1: 1 clamps negative results to 0; 0 passes them through.
- WIDTH, 56: output pixels per row.
- HEIGHT, 56: rows per frame.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of pipeline valids and counters, active-high.
- in_valid  in  1  in_data holds one pixel's channel results.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  NUM_CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_WIDTH  saturated, biased, optionally rectified sum.
- out_eol  out  1  output pixel is the last of its row.
- out_last  out  1  output pixel is the last of the frame.

## Operation
- Pipeline enable: en = !out_valid || out_ready. When en is 0, every stage holds.
- in_ready = en && !clr. An input is accepted when in_valid && in_ready.
- Stage 0 registers the inputs. Levels 1..L_T form a pairwise adder tree with one register per level, where L_T = clog2(padded N). The final stage adds BIAS, saturates and applies ReLU.
- Accumulator width is ACC_W = DATA_WIDTH + L_T + 1, sign-extended at every level. The tree itself never overflows.
- Saturation: sum + BIAS is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- ReLU (when RELU_EN=1): results below 0 become 0. This is applied after saturation.
- A valid bit travels with each stage's data and advances only when en=1. Data registers of invalid slots are don't-care.
- Counters: col runs 0..WIDTH-1 and row runs 0..HEIGHT-1. Both advance on each output handshake (out_valid && out_ready).
  - col wraps to 0 at WIDTH-1, and row then increments.
  - row wraps to 0 at HEIGHT-1, so the next frame starts at (0,0) automatically.
- out_eol = (col==WIDTH-1). out_last = out_eol && (row==HEIGHT-1). Both flags are combinational from the counters and meaningful only while out_valid=1.
- clr=1: all valid bits clear, col and row clear, and no input is accepted that cycle. clr wins over a simultaneous in_valid or output handshake.
- Reset (rst=0), asynchronous: all valid bits 0 and counters 0. Resulting output values: out_valid=0, out_data=0, out_eol=0, out_last=0, in_ready=1. Assertion mid-frame discards all in-flight pixels.

## Timing
- Latency: an input accepted at edge k appears as out_valid at edge k+L, where L = L_T+2 (L=6 for N=16, L=3 for N=2). This holds with out_ready held at 1.
- Throughput: one pixel per cycle with out_ready=1. There are no bubbles between back-to-back inputs.
- Back-pressure: with out_valid=1 and out_ready=0, out_data, out_eol and out_last hold stable, and in_ready=0 the same cycle (combinational). No data is lost or duplicated.
- The bubble-collapsing pipeline is not required; holding all stages on en=0 is the specified behaviour.
- Pipeline depth and counters are independent of in_valid gaps. Gaps propagate as bubbles.
- out_ready toggling while out_valid=0 has no effect.

## Test plan
- Identity: N=16, all channels=1.0 in Q8.8 (0x0100), BIAS=0x0080, out_ready=1 → out_data=0x1080, exactly 6 cycles after acceptance.
- Saturation and ReLU: all channels=0x7000 → out_data=0x7FFF. All channels=0x9000 with RELU_EN=1 → 0x0000. The same input with RELU_EN=0 → 0x8000.
- Back-pressure: stream 20 random pixels with out_ready driven by a random 50% pattern → outputs match a reference model in order. in_ready=0 whenever out_valid && !out_ready.
- Frame tags: WIDTH=4, HEIGHT=3, 24 pixels streamed → out_eol on pixels 4, 8, 12, 16, 20, 24. out_last on pixels 12 and 24.
- clr mid-stream: clr pulsed with 3 pixels in flight and in_valid=1 → those 3 pixels and the clr-cycle input never appear. The next output has col=0, row=0.
- Async reset mid-frame: rst low for 1 ns between edges → out_valid=0 immediately. After release, the next frame starts at (0,0).
- Non-power-of-two: NUM_CHANNELS=3, inputs {5, -2, 7}, BIAS=0 → out_data=10 with latency 4.

Source files
------------

// File: rtl/featuremap_accum_bias.sv
// featuremap_accum_bias
// Channel-reduction stage for one output pixel: a registered input stage, a
// pairwise adder tree with one register per level, a registered bias add and
// a registered saturate/ReLU output. Every stage stalls together when the
// output is held by back-pressure. Row/column counters tag end-of-row and
// end-of-frame on each output pixel.
module featuremap_accum_bias #(
  parameter int                           DATA_WIDTH   = 16,
  parameter int                           NUM_CHANNELS = 16,
  parameter logic signed [DATA_WIDTH-1:0] BIAS         = '0,
  parameter int                           RELU_EN      = 1,
  parameter int                           WIDTH        = 56,
  parameter int                           HEIGHT       = 56
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_eol,
  output logic                               out_last
);

  // Tree geometry: channel count padded up to a power of two.
  localparam int L_T   = $clog2(NUM_CHANNELS);
  localparam int NP    = 1 << L_T;
  localparam int ACC_W = DATA_WIDTH + L_T + 1;

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  localparam logic signed [ACC_W-1:0] BIAS_X =
    {{(ACC_W-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return {{(ACC_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

  logic                      en;
  logic                      hs;
  logic [NP*DATA_WIDTH-1:0]  in_pad;
  // vld[0] is the input stage, vld[1..L_T] the tree levels, vld[L_T+1] the bias stage.
  logic [L_T+1:0]            vld;
  logic signed [ACC_W-1:0]   tree [0:L_T][0:NP-1];
  logic signed [ACC_W-1:0]   biased;
  logic [DATA_WIDTH-1:0]     sat_val;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !clr;
  assign hs       = out_valid && out_ready;

  // Missing channels of a non-power-of-two count read as zero.
  assign in_pad = (NP*DATA_WIDTH)'(in_data);

  // Valid bits advance with the data; clr and reset empty the whole pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      vld       <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld       <= {vld[L_T:0], in_valid};
      out_valid <= vld[L_T+1];
    end
  end

  // Input capture and adder-tree levels; contents of empty slots are ignored.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int c = 0; c < NP; c++) begin
        tree[0][c] <= sext(in_pad[c*DATA_WIDTH +: DATA_WIDTH]);
      end
      for (int lv = 1; lv <= L_T; lv++) begin
        for (int j = 0; j < NP/2; j++) begin
          if (j < (NP >> lv)) begin
            tree[lv][j] <= tree[lv-1][2*j] + tree[lv-1][2*j+1];
          end
        end
      end
    end
  end

  // Bias add gets its own register so the clamp logic starts from a flop.
  always_ff @(posedge clk) begin
    if (en) begin
      biased <= tree[L_T][0] + BIAS_X;
    end
  end

  // Clamp to the output range, then rectify.
  always_comb begin
    sat_val = biased[DATA_WIDTH-1:0];
    if (biased > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    end else if (biased < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_WIDTH-1:0];
    end
    if ((RELU_EN != 0) && sat_val[DATA_WIDTH-1]) begin
      sat_val = '0;
    end
  end

  // Output data register; holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
    end else if (en) begin
      out_data <= sat_val;
    end
  end

  // Pixel position of the current output, stepped on each output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (hs) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Flags are gated with out_valid so they read 0 whenever no pixel is presented.
  assign out_eol  = out_valid && (col == COL_LAST);
  assign out_last = out_eol && (row == ROW_LAST);

endmodule

// File: tb/tb_featuremap_accum_bias.sv
// Directed bench for featuremap_accum_bias: three instances cover
// N=16 with ReLU, N=16 without ReLU, and N=3 (padded tree).
module tb_featuremap_accum_bias;

  logic clk, rst, clr;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_eol, a_out_last;
  logic [255:0] a_in_data;
  logic [15:0]  a_out_data;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_eol, b_out_last;
  logic [255:0] b_in_data;
  logic [15:0]  b_out_data;

  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_eol, c_out_last;
  logic [47:0]  c_in_data;
  logic [15:0]  c_out_data;

  int n_vec;
  int n_err;

  featuremap_accum_bias #(.DATA_WIDTH(16), .NUM_CHANNELS(16), .BIAS(16'sh0080),
                          .RELU_EN(1), .WIDTH(4), .HEIGHT(3)) u_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_eol(a_out_eol), .out_last(a_out_last));

  featuremap_accum_bias #(.DATA_WIDTH(16), .NUM_CHANNELS(16), .BIAS(16'sh0080),
                          .RELU_EN(0), .WIDTH(4), .HEIGHT(3)) u_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_eol(b_out_eol), .out_last(b_out_last));

  featuremap_accum_bias #(.DATA_WIDTH(16), .NUM_CHANNELS(3), .BIAS(16'sh0000),
                          .RELU_EN(1), .WIDTH(4), .HEIGHT(3)) u_c (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_eol(c_out_eol), .out_last(c_out_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic out_v(input int sel);
    case (sel)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic [15:0] out_d(input int sel);
    case (sel)
      0:       return a_out_data;
      1:       return b_out_data;
      default: return c_out_data;
    endcase
  endfunction

  // Reference for instance a: sum + 0x80, clamp to 16 bits, ReLU.
  function automatic logic [15:0] model_a(input logic [255:0] d);
    int s;
    s = 128;
    for (int c = 0; c < 16; c++) s += int'($signed(d[c*16 +: 16]));
    if (s > 32767) s = 32767;
    if (s < 0) s = 0;
    return 16'(s);
  endfunction

  // One pixel into the selected instance, then count cycles until out_valid.
  task automatic send_one(input int sel, input logic [255:0] d, output int lat, output logic [15:0] q);
    case (sel)
      0:       begin a_in_data = d; a_in_valid = 1'b1; end
      1:       begin b_in_data = d; b_in_valid = 1'b1; end
      default: begin c_in_data = d[47:0]; c_in_valid = 1'b1; end
    endcase
    tick();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    lat = 0;
    while (!out_v(sel) && lat < 20) begin
      tick();
      lat++;
    end
    q = out_d(sel);
  endtask

  // Streams n pixels (all channels = base+i) into instance a with out_ready=1
  // and checks data plus eol/last tags assuming the stream starts at (0,0).
  task automatic stream_check(input string tag, input int n, input int base);
    int sent, got;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      a_in_valid = (sent < n);
      a_in_data  = {16{16'(base + sent)}};
      #1;
      if (a_out_valid && a_out_ready) begin
        check({tag, "_data"}, 32'(a_out_data), 32'(16*(base+got) + 128));
        check({tag, "_eol"},  32'(a_out_eol),  32'(got % 4 == 3));
        check({tag, "_last"}, 32'(a_out_last), 32'(got % 12 == 11));
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
      tick();
    end
    a_in_valid = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int           lat;
    logic [15:0]  q;
    logic [255:0] vec;
    logic [255:0] pix [20];
    logic [15:0]  exp_q [$];
    logic [15:0]  expv, held;
    int           sent, got, stray;
    logic         stalled;

    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    clr = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

    tick();
    tick();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data",  32'(a_out_data),  32'd0);
    check("rst_out_eol",   32'(a_out_eol),   32'd0);
    check("rst_out_last",  32'(a_out_last),  32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    rst = 1'b1;
    tick();

    // 16 x 1.0 + 0.5 in Q8.8
    send_one(0, {16{16'h0100}}, lat, q);
    check("id_latency", 32'(lat), 32'd6);
    check("id_data",    32'(q),   32'h1080);

    send_one(0, {16{16'h7000}}, lat, q);
    check("sat_hi_latency", 32'(lat), 32'd6);
    check("sat_hi_data",    32'(q),   32'h7FFF);

    send_one(0, {16{16'h9000}}, lat, q);
    check("relu_neg_data", 32'(q), 32'h0000);

    send_one(1, {16{16'h9000}}, lat, q);
    check("norelu_sat_lo_data", 32'(q), 32'h8000);

    // -4096 + 128 = -3968 passes through without ReLU
    send_one(1, {16{16'hFF00}}, lat, q);
    check("norelu_neg_data", 32'(q), 32'hF080);

    vec = 256'({16'd7, 16'hFFFE, 16'd5});
    send_one(2, vec, lat, q);
    check("n3_latency", 32'(lat), 32'd4);
    check("n3_data",    32'(q),   32'd10);

    // 3 - 2 - 5 = -4 -> 0
    vec = 256'({16'd3, 16'hFFFE, 16'hFFFB});
    send_one(2, vec, lat, q);
    check("n3_relu_data", 32'(q), 32'd0);

    vec = 256'({16'h7FFF, 16'h7FFF, 16'h7FFF});
    send_one(2, vec, lat, q);
    check("n3_sat_data", 32'(q), 32'h7FFF);

    // Frame tags: restart counters, then two full 4x3 frames.
    clr = 1'b1;
    #1;
    check("clr_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    clr = 1'b0;
    stream_check("frame", 24, 1);

    // Back-pressure with random out_ready against the reference model.
    for (int p = 0; p < 20; p++)
      for (int c = 0; c < 16; c++)
        pix[p][c*16 +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
    sent = 0;
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_valid  = (sent < 20);
      a_in_data   = pix[(sent < 20) ? sent : 0];
      #1;
      if (stalled) begin
        check("bp_hold_valid", 32'(a_out_valid), 32'd1);
        check("bp_hold_data",  32'(a_out_data),  32'(held));
      end
      if (a_out_valid && !a_out_ready) begin
        check("bp_in_ready", 32'(a_in_ready), 32'd0);
        stalled = 1'b1;
        held = a_out_data;
      end else begin
        stalled = 1'b0;
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        else expv = 16'hDEAD;
        check("bp_data", 32'(a_out_data), 32'(expv));
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        exp_q.push_back(model_a(pix[sent]));
        sent++;
      end
      tick();
    end
    a_out_ready = 1'b1;
    a_in_valid = 1'b0;
    check("bp_count", 32'(got), 32'd20);

    // clr with three pixels in flight and a fourth offered in the clr cycle.
    send_one(0, {16{16'h0001}}, lat, q);
    send_one(0, {16{16'h0002}}, lat, q);
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = {16{16'(10 + k)}};
      tick();
    end
    a_in_data = {16{16'd13}};
    clr = 1'b1;
    #1;
    check("clr_cycle_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    clr = 1'b0;
    stream_check("after_clr", 4, 20);

    // Async reset while a pixel is stalled at the output and others in flight.
    send_one(0, {16{16'h0001}}, lat, q);
    send_one(0, {16{16'h0002}}, lat, q);
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = {16{16'(40 + k)}};
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("pre_rst_out_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("async_rst_out_data",  32'(a_out_data),  32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    check("post_rst_out_valid", 32'(a_out_valid), 32'd0);
    tick();
    a_out_ready = 1'b1;
    stream_check("after_rst", 4, 30);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_out_valid) stray++;
      tick();
    end
    check("after_rst_stray", 32'(stray), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
